// File: rtl/reg_bank_reader.sv
// ---------------------------------------------------------------------------
// reg_bank_reader
//   Read-side sequencer for a register bank with a synchronous read port.
//   Takes a burst request (base index, count), issues one read strobe per
//   register with the index wrapping modulo DEPTH, and streams the returned
//   values out through a 2-entry ready/valid buffer. The debug/trace path
//   uses it to dump architectural state without touching the write side.
//
//   Optional feature, macro REG_READER_TAG_EN:
//     when defined, each buffered word also carries its source index and
//     the out_index port exists. With the macro undefined the port and
//     the index storage are absent, and behaviour is otherwise identical.
//
// Parameters
//   WIDTH   data width of each register
//   DEPTH   number of registers in the bank (power of two)
//   IDX_W   index width, log2(DEPTH)
//
// Ports
//   clock      sole clock, all state on posedge
//   reset_n    synchronous active-low reset
//   req_valid  burst request present
//   req_ready  reader idle and able to accept a request
//   req_base   first register index
//   req_count  registers to read, 0..DEPTH (0 is consumed as a no-op)
//   rd_en      read strobe to the bank
//   rd_addr    read index, forced to 0 when rd_en=0
//   rd_data    bank read data, valid the cycle after rd_en
//   out_valid  output word present
//   out_ready  consumer accepts the word
//   out_data   register value at the head of the buffer
//   out_last   head word is the final word of the burst
//   busy       burst in progress (!req_ready)
//   out_index  source index of out_data (REG_READER_TAG_EN only)
// ---------------------------------------------------------------------------
module reg_bank_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_base,
  input  logic [IDX_W:0]   req_count,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
`ifdef REG_READER_TAG_EN
  ,
  output logic [IDX_W-1:0] out_index
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // One buffer slot: read data plus, optionally, the index it came from.
  typedef struct packed {
    logic [WIDTH-1:0] data;
`ifdef REG_READER_TAG_EN
    logic [IDX_W-1:0] idx;
`endif
  } ent_t;

  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] CNT_ZERO = '0;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] addr_q;     // next index to read
  logic [IDX_W:0]   iss_cnt_q;  // reads still to issue
  logic [IDX_W:0]   out_cnt_q;  // words still to pop; 1 => head is last
  logic             infl_q;     // a read was issued last cycle
`ifdef REG_READER_TAG_EN
  logic [IDX_W-1:0] infl_idx_q; // index of the in-flight read
`endif

  ent_t             buf_q [2];
  logic             wptr_q, rptr_q;
  logic [1:0]       occ_q;

  logic accept, pop, push, credit_ok;

  // -------------------------------------------------------------------------
  // Handshakes and credit
  // -------------------------------------------------------------------------
  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = infl_q;
  assign accept    = req_valid && req_ready;

  // Buffered plus in-flight words never exceed the two buffer slots. A pop
  // in the same cycle frees a slot, so issue may proceed even when full;
  // that keeps the stream at one word per cycle with out_ready held high.
  assign credit_ok = ((occ_q + {1'b0, infl_q}) < 2'd2);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && (req_count != CNT_ZERO)) state_d = S_ISSUE;
      S_ISSUE: if (rd_en && (iss_cnt_q == CNT_ONE))   state_d = S_DRAIN;
      S_DRAIN: if (pop && out_last)                   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    req_ready = (state_q == S_IDLE);
    busy      = !req_ready;
    rd_en     = (state_q == S_ISSUE) && (credit_ok || pop);
    rd_addr   = rd_en ? addr_q : '0;
  end

  // -------------------------------------------------------------------------
  // Address / counters / in-flight tracking
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr_q     <= '0;
      iss_cnt_q  <= '0;
      out_cnt_q  <= '0;
      infl_q     <= 1'b0;
`ifdef REG_READER_TAG_EN
      infl_idx_q <= '0;
`endif
    end else begin
      // accept only happens in IDLE and rd_en only in ISSUE, so the two
      // updates never collide. A zero-count request latches harmless zeros.
      if (accept) begin
        addr_q    <= req_base;
        iss_cnt_q <= req_count;
      end else if (rd_en) begin
        addr_q    <= addr_q + 1'b1;   // wraps modulo DEPTH (power of two)
        iss_cnt_q <= iss_cnt_q - 1'b1;
      end

      // The buffer is always empty in IDLE, so pop and accept are exclusive.
      if (accept)   out_cnt_q <= req_count;
      else if (pop) out_cnt_q <= out_cnt_q - 1'b1;

      // Cleared by reset, so data returning just after a reset is dropped.
      infl_q <= rd_en;
`ifdef REG_READER_TAG_EN
      if (rd_en) infl_idx_q <= addr_q;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // 2-entry output buffer
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wptr_q].data <= rd_data;
`ifdef REG_READER_TAG_EN
        buf_q[wptr_q].idx  <= infl_idx_q;
`endif
        wptr_q <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Head fields come straight from storage, so they stay put under
  // back-pressure: the read pointer only moves on a pop.
  assign out_data = buf_q[rptr_q].data;
  assign out_last = out_valid && (out_cnt_q == CNT_ONE);
`ifdef REG_READER_TAG_EN
  assign out_index = buf_q[rptr_q].idx;
`endif

endmodule

// File: tb/tb_reg_bank_reader.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_reader
//   Directed bench for reg_bank_reader. A bank model returns reg[i]=0x100+i
//   one cycle after each read strobe; a negedge monitor logs read strobes
//   and popped words, which are checked against hand-derived expectations.
// ---------------------------------------------------------------------------
module tb_reg_bank_reader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_base;
  logic [5:0]  req_count;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
`ifdef REG_READER_TAG_EN
  logic [4:0]  out_index;
`endif

  reg_bank_reader #(.WIDTH(32), .DEPTH(32), .IDX_W(5)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_base  (req_base),
    .req_count (req_count),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
`ifdef REG_READER_TAG_EN
    ,
    .out_index (out_index)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Bank model: synchronous read, junk when not strobed.
  logic [31:0] bank [32];
  initial for (int i = 0; i < 32; i++) bank[i] = 32'h100 + i;
  always @(posedge clock) rd_data <= rd_en ? bank[rd_addr] : 32'hDEAD_BEEF;

  // Monitor, sampled mid-cycle.
  int          rd_log[$];
  int          rd_cyc[$];
  logic [31:0] pd[$];
  logic        pl[$];
  int          pi[$];
  int          pc[$];
  always @(negedge clock) begin
    if (rd_en) begin
      rd_log.push_back(int'(rd_addr));
      rd_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      pd.push_back(out_data);
      pl.push_back(out_last);
`ifdef REG_READER_TAG_EN
      pi.push_back(int'(out_index));
`else
      pi.push_back(0);
`endif
      pc.push_back(cyc);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clr;
    rd_log.delete(); rd_cyc.delete();
    pd.delete(); pl.delete(); pi.delete(); pc.delete();
  endtask

  // Present a request for one cycle; t is the accept cycle.
  task automatic send_req(input int b, input int c, output int t);
    req_valid = 1'b1;
    req_base  = 5'(b);
    req_count = 6'(c);
    chk("req_rdy", req_ready, 1);
    t = cyc;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic run_to(input int c);
    int k = 0;
    while (cyc < c && k < 1000) begin tick; k++; end
  endtask

  // Reads in wrap order, data 0x100+idx, last only on the final word; with
  // timed=1 also first read at t+1 and word i popped at t+3+i.
  task automatic check_burst(input string nm, input int b, input int c,
                             input int t, input bit timed);
    int idx;
    chk({nm, "_nrd"},  rd_log.size(), c);
    chk({nm, "_npop"}, pd.size(), c);
    if (timed && rd_cyc.size() > 0) chk({nm, "_rd0cyc"}, rd_cyc[0], t + 1);
    for (int i = 0; i < c; i++) begin
      idx = (b + i) % 32;
      if (i < rd_log.size()) chk({nm, "_addr"}, rd_log[i], idx);
      if (i < pd.size()) begin
        chk({nm, "_data"}, pd[i], 32'h100 + idx);
        chk({nm, "_last"}, pl[i], (i == c - 1));
`ifdef REG_READER_TAG_EN
        chk({nm, "_idx"}, pi[i], idx);
`endif
        if (timed) chk({nm, "_cyc"}, pc[i], t + 3 + i);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int t, r, k;
    reset_n = 1'b0; req_valid = 1'b0; req_base = '0; req_count = '0;
    out_ready = 1'b1;
    repeat (3) tick;

    // Reset state
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy",      busy, 0);
    chk("rst_rd_en",     rd_en, 0);
    chk("rst_rd_addr",   rd_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_out_last",  out_last, 0);
`ifdef REG_READER_TAG_EN
    chk("rst_out_index", out_index, 0);
`endif
    reset_n = 1'b1;
    tick;

    // Basic burst: base 3, count 4
    clr;
    send_req(3, 4, t);
    run_to(t + 6);
    chk("basic_busy_t6", busy, 1);
    tick;
    chk("basic_rdy_t7", req_ready, 1);
    check_burst("basic", 3, 4, t, 1);

    // Wrap-around: 30,31,0,1
    clr;
    send_req(30, 4, t);
    run_to(t + 8);
    check_burst("wrap", 30, 4, t, 1);

    // Back-pressure: out_ready low for 10 cycles
    clr;
    out_ready = 1'b0;
    send_req(0, 8, t);
    repeat (10) tick;
    chk("bp_nrd",   rd_log.size(), 2);
    chk("bp_valid", out_valid, 1);
    chk("bp_hold",  out_data, 32'h100);
    r = cyc;
    out_ready = 1'b1;
    repeat (12) tick;
    if (rd_cyc.size() > 2) chk("bp_resume", rd_cyc[2], r);
    for (int i = 1; i < pc.size(); i++) chk("bp_gap", pc[i], pc[0] + i);
    check_burst("bp", 0, 8, t, 0);
    chk("bp_idle", req_ready, 1);

    // Zero count
    clr;
    send_req(0, 0, t);
    chk("zero_rdy",  req_ready, 1);
    chk("zero_busy", busy, 0);
    repeat (4) tick;
    chk("zero_nrd",  rd_log.size(), 0);
    chk("zero_npop", pd.size(), 0);

    // Request while busy is not consumed
    clr;
    send_req(10, 3, t);
    req_valid = 1'b1; req_base = 5'd20; req_count = 6'd2;
    chk("busy_rdy1", req_ready, 0);
    chk("busy_busy", busy, 1);
    tick;
    chk("busy_rdy2", req_ready, 0);
    req_valid = 1'b0;
    run_to(t + 7);
    check_burst("busy", 10, 3, t, 1);
    chk("busy_idle", req_ready, 1);

    // Reset during DRAIN with two words buffered
    clr;
    out_ready = 1'b0;
    send_req(0, 2, t);
    run_to(t + 4);
    chk("mrst_pre_valid", out_valid, 1);
    chk("mrst_pre_busy",  busy, 1);
    reset_n = 1'b0;
    tick;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy",  busy, 0);
    chk("mrst_rd_en", rd_en, 0);
    chk("mrst_rdy",   req_ready, 1);
    chk("mrst_data",  out_data, 0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    tick;
    clr;
    send_req(3, 4, t);
    run_to(t + 7);
    chk("mrst_rdy_t7", req_ready, 1);
    check_burst("mrst", 3, 4, t, 1);

    // Full depth with random back-pressure
    clr;
    send_req(5, 32, t);
    k = 0;
    while (pd.size() < 32 && k < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      tick;
      k++;
    end
    out_ready = 1'b1;
    repeat (3) tick;
    chk("full_in_time", (k < 400), 1);
    check_burst("full", 5, 32, t, 0);
    if (pl.size() == 32) chk("full_last_idx4", pl[31], 1);
    chk("full_idle", req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_reader.md
# reg_bank_reader

Read-side sequencer for a bank of `single_register`-style storage, such as the register file or CSR bank.
- Accepts a burst request (base index, count) and issues single-cycle read strobes to the bank's synchronous read port.
- Returns each value on a ready/valid output stream through a 2-entry output buffer.
- Used by the debug/trace path to dump architectural state without stalling the core's write side.

## Interface
Parameters:
- `WIDTH`, 32, data width of each register
- `DEPTH`, 32, number of registers in the bank; power of two
- `IDX_W`, 5, index width, equal to log2(DEPTH)

Ports:
- `clock`  in  1  sole clock; all state updates on posedge
- `reset_n`  in  1  synchronous, active-low reset
- `req_valid`  in  1  burst request present
- `req_ready`  out  1  reader can accept a request
- `req_base`  in  IDX_W  first register index
- `req_count`  in  IDX_W+1  number of registers to read, 0..DEPTH
- `rd_en`  out  1  read strobe to bank
- `rd_addr`  out  IDX_W  read index; valid when `rd_en`=1
- `rd_data`  in  WIDTH  bank read data; valid exactly one cycle after `rd_en`
- `out_valid`  out  1  output word present
- `out_ready`  in  1  consumer accepts the word
- `out_data`  out  WIDTH  register value
- `out_last`  out  1  marks final word of burst
- `busy`  out  1  burst in progress; equals !`req_ready`
- `out_index`  out  IDX_W  source index of `out_data`; present only with `REG_READER_TAG_EN`

## Operation
- **States:**
  - IDLE: `req_ready`=1.
  - ISSUE: reads remain to be issued.
  - DRAIN: all reads issued; waiting for in-flight read and buffer to empty.
- **IDLE → ISSUE:** on `req_valid && req_ready` with `req_count` ≠ 0. Latch the base into the address counter and the count into the issue counter. Capture the output counter separately.
- **IDLE → IDLE:** on a request with `req_count` = 0. The request is consumed and produces no reads and no output.
- **ISSUE:**
  - A read is issued when (buffer occupancy + in-flight) < 2, or when a pop occurs in the same cycle.
  - Each issue decrements the issue counter.
  - The address increments modulo DEPTH: `DEPTH-1` wraps to 0.
- **ISSUE → DRAIN:** when the last read is issued.
- **DRAIN → IDLE:** in the cycle the word with `out_last`=1 is popped.
- **In-flight tracking:** 1-bit flag set by `rd_en`. The returned `rd_data` is pushed into the buffer on the following edge. Data can never be dropped, because the credit rule prevents overflow.
- **Output buffer:**
  - 2-entry FIFO; the head drives `out_data`/`out_last`.
  - Pop on `out_valid && out_ready`.
  - Head fields are held stable while `out_valid && !out_ready`.
- **`out_last`:** set on the word whose output counter reaches 1.
- **Requests:** ignored while busy; `req_ready`=0 outside IDLE.
- **Output port mux:** `rd_addr` = 0 when `rd_en`=0.

## Timing
- **Reset values:** `req_ready`=1, `busy`=0, `rd_en`=0, `rd_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `out_index`=0. State = IDLE, buffer empty, in-flight cleared.
- **Reset mid-burst:** abort immediately. Any `rd_data` returning in the cycle after reset is discarded.
- **Latency:**
  - Request accepted in cycle T.
  - First `rd_en` in T+1.
  - `rd_data` is sampled in T+2.
  - First `out_valid` in T+3.
- **Throughput:** with `out_ready` held high, one word per cycle. A burst of N completes with `out_last` popped in T+2+N; `req_ready` is 1 in T+3+N.
- **Back-pressure:** with `out_ready` low, at most 2 words are buffered and no further `rd_en` is issued. Issue resumes in the same cycle `out_ready` pops.
- **Simultaneous push and pop:** with a full buffer, push and pop in the same cycle keep occupancy unchanged.

## Configuration
- Macro: `REG_READER_TAG_EN`.
- **Defined:**
  - Each buffer entry also stores the read index.
  - The `out_index` port exists and carries the register index of the head word, with the same stability rule as `out_data`.
- **Undefined:** no `out_index` port and no index storage. All other behaviour is identical.

## Test plan
- **Basic burst:** reset, bank preloaded with reg[i]=0x100+i; request base=3, count=4, `out_ready`=1.
  - Words 0x103..0x106 appear in T+3..T+6.
  - `out_last` is set only on 0x106.
  - `req_ready` returns in T+7.
- **Wrap-around:** base=30, count=4.
  - `rd_addr` sequence is 30, 31, 0, 1.
  - Data out is 0x11E, 0x11F, 0x100, 0x101.
  - With the macro defined, `out_index` is 30, 31, 0, 1.
- **Back-pressure:** `out_ready`=0 for 10 cycles after request, base=0, count=8.
  - Exactly 2 `rd_en` pulses occur, and `out_data` holds 0x100.
  - After release, all 8 words arrive in order with no gaps.
- **Zero count and busy:**
  - count=0: consumed in one cycle, no `rd_en`, no `out_valid`.
  - A second request during a burst sees `req_ready`=0 and is not consumed.
- **Reset mid-burst:** `reset_n` low during DRAIN with 2 words buffered.
  - Next cycle: `out_valid`=0, `busy`=0, `rd_en`=0.
  - A new request then behaves as in the basic burst test.
- **Full DEPTH:** count=32, base=5, random `out_ready`.
  - All 32 registers are read exactly once, in wrap order.
  - `out_last` is set on index 4.
